idex_pipe_reg: RTL and testbench

- Parametrised successor to the fixed-field decode→execute pipeline register.
- Carries one opaque payload bus of DATA_W bits, carrying operands, instruction, pc, jump info and wb addr as the packer defines.
- Uses valid/ready handshakes on both sides, plus the existing ctrlU flush/stall controls.
- SKID_EN adds an optional second entry so in_ready is registered, plus a saturating bubble counter for performance monitoring.
- Sits between IDU decode and EXU; reusable for EX→MEM.

---
 rtl/idex_pipe_reg.sv | 107 ++++++++++
 tb/tb_idex_pipe_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/idex_pipe_reg.sv
// Decode-to-execute pipeline register with valid/ready handshakes.
// It carries one opaque payload and holds up to two entries when the skid entry is enabled.
// It also keeps a saturating count of the cycles in which no live beat is offered downstream.
module idex_pipe_reg #(
  parameter int                DATA_W  = 168,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter bit                SKID_EN = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr_en,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_v;
  logic [DATA_W-1:0] main_data;
  logic              main_wr;
  logic              skid_v;
  logic [DATA_W-1:0] skid_data;
  logic              skid_wr;
  logic              fire_in;
  logic              fire_out;
  logic              main_take;

  // With the skid entry, ready comes from registered state only; otherwise a draining main entry may refill.
  always_comb begin
    in_ready = 1'b0;
    if (SKID_EN) begin
      in_ready = ~stall & ~skid_v;
    end else begin
      in_ready = ~stall & (~main_v | out_ready);
    end
  end

  // Transfer events on each side; main can take a new beat when it is empty or being drained.
  always_comb begin
    fire_in   = in_valid & in_ready;
    fire_out  = main_v & out_ready & ~stall;
    main_take = ~main_v | fire_out;
  end

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_wr_en = main_wr;

  // Entry storage: reset and flush empty both entries, stall freezes them, otherwise the pair moves as a FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v    <= 1'b0;
      main_data <= NOP_VAL;
      main_wr   <= 1'b0;
      skid_v    <= 1'b0;
      skid_data <= NOP_VAL;
      skid_wr   <= 1'b0;
    end else if (flush) begin
      main_v    <= 1'b0;
      main_data <= NOP_VAL;
      main_wr   <= 1'b0;
      skid_v    <= 1'b0;
    end else if (!stall) begin
      if (main_take) begin
        if (skid_v) begin
          main_v    <= 1'b1;
          main_data <= skid_data;
          main_wr   <= skid_wr;
          skid_v    <= fire_in;
          if (fire_in) begin
            skid_data <= in_data;
            skid_wr   <= in_wr_en;
          end
        end else if (fire_in) begin
          main_v    <= 1'b1;
          main_data <= in_data;
          main_wr   <= in_wr_en;
        end else begin
          main_v <= 1'b0;
        end
      end else if (fire_in && SKID_EN) begin
        skid_v    <= 1'b1;
        skid_data <= in_data;
        skid_wr   <= in_wr_en;
      end
    end
  end

  // Count idle output cycles, including flush cycles, but not stalled ones; stop at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!stall && !main_v && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Self-checking bench for idex_pipe_reg.
// It runs a skid-enabled narrow instance and a single-entry full-width instance side by side.
// Both are checked against a FIFO-occupancy reference model.
// A directed table of vectors with hand-derived expectations is also checked against the skid instance.
module tb_idex_pipe_reg;

  typedef logic [168:0] ent_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        stall;
    logic        iv;
    logic [31:0] idata;
    logic        iwr;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic        ew;
    logic        eir;
    logic [2:0]  ec;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, flush, stall, in_valid, in_wr_en, out_ready;
  logic [167:0] in_data;

  logic         ir0, ov0, ow0;
  logic [31:0]  od0;
  logic [2:0]   bc0;
  logic         ir1, ov1, ow1;
  logic [167:0] od1;
  logic [15:0]  bc1;

  int nvec = 0;
  int nerr = 0;

  ent_t fifo [2][2];
  int   occ [2];
  ent_t hold [2];
  int   mcnt [2];
  int   cnt_max [2] = '{7, 65535};
  bit   skid [2] = '{1'b1, 1'b0};
  ent_t mask [2];
  ent_t nop [2];

  vec_t tbl [$];

  always #5 clk = ~clk;

  idex_pipe_reg #(.DATA_W(32), .NOP_VAL(32'h0000_0013), .SKID_EN(1'b1), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data[31:0]), .in_wr_en(in_wr_en),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_wr_en(ow0),
    .bubble_cnt(bc0)
  );

  idex_pipe_reg #(.SKID_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_wr_en(in_wr_en),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_wr_en(ow1),
    .bubble_cnt(bc1)
  );

  function automatic bit mready(input int i);
    if (stall) return 1'b0;
    if (skid[i]) return occ[i] < 2;
    return (occ[i] == 0) || out_ready;
  endfunction

  task automatic modelStep(input int i);
    bit fin, fout;
    fin  = in_valid && mready(i);
    fout = (occ[i] > 0) && out_ready && !stall;
    if (rst) begin
      occ[i]  = 0;
      hold[i] = nop[i];
      mcnt[i] = 0;
    end else if (flush) begin
      if (occ[i] == 0 && !stall && mcnt[i] < cnt_max[i]) mcnt[i]++;
      occ[i]  = 0;
      hold[i] = nop[i];
    end else if (!stall) begin
      if (occ[i] == 0 && mcnt[i] < cnt_max[i]) mcnt[i]++;
      if (fout) begin
        fifo[i][0] = fifo[i][1];
        occ[i]--;
      end
      if (fin && occ[i] < 2) begin
        fifo[i][occ[i]] = {in_wr_en, in_data} & mask[i];
        occ[i]++;
      end
      if (occ[i] > 0) hold[i] = fifo[i][0];
    end
  endtask

  task automatic cmp(input string nm, input ent_t act, input ent_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input int i);
    if (i == 0) begin
      cmp("dut0 out_valid", ent_t'(ov0), ent_t'(occ[0] > 0));
      cmp("dut0 out_data", ent_t'(od0), ent_t'(hold[0][31:0]));
      cmp("dut0 out_wr_en", ent_t'(ow0), ent_t'(hold[0][168]));
      cmp("dut0 in_ready", ent_t'(ir0), ent_t'(mready(0)));
      cmp("dut0 bubble_cnt", ent_t'(bc0), ent_t'(mcnt[0]));
    end else begin
      cmp("dut1 out_valid", ent_t'(ov1), ent_t'(occ[1] > 0));
      cmp("dut1 out_data", ent_t'(od1), ent_t'(hold[1][167:0]));
      cmp("dut1 out_wr_en", ent_t'(ow1), ent_t'(hold[1][168]));
      cmp("dut1 in_ready", ent_t'(ir1), ent_t'(mready(1)));
      cmp("dut1 bubble_cnt", ent_t'(bc1), ent_t'(mcnt[1]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic s, input logic iv,
                               input logic [167:0] d, input logic wr, input logic ordy);
    rst       = r;
    flush     = f;
    stall     = s;
    in_valid  = iv;
    in_data   = d;
    in_wr_en  = wr;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    checkOutput(0);
    checkOutput(1);
  endtask

  task automatic addRow(input logic r, input logic f, input logic s, input logic iv,
                        input logic [31:0] d, input logic wr, input logic ordy,
                        input logic ev, input logic [31:0] ed, input logic ew,
                        input logic eir, input logic [2:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = s; v.iv = iv; v.idata = d; v.iwr = wr; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ew = ew; v.eir = eir; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    mask[0] = {1'b1, {136{1'b0}}, {32{1'b1}}};
    mask[1] = '1;
    nop[0]  = ent_t'(32'h0000_0013);
    nop[1]  = '0;
    occ     = '{0, 0};
    mcnt    = '{0, 0};
    hold    = '{nop[0], nop[1]};

    //     rst flush stall iv data   wr  ordy | ov  out_data wr  ir  cnt
    addRow(1, 0, 0, 1, 32'hAA, 1, 0,   0, 32'h13, 0, 1, 3'd0);
    addRow(1, 0, 0, 1, 32'hAA, 1, 0,   0, 32'h13, 0, 1, 3'd0);
    addRow(0, 0, 0, 1, 32'hAA, 1, 0,   1, 32'hAA, 1, 1, 3'd1);
    addRow(0, 0, 0, 1, 32'hBB, 0, 0,   1, 32'hAA, 1, 0, 3'd1);
    addRow(0, 0, 0, 1, 32'hCC, 1, 1,   1, 32'hBB, 0, 1, 3'd1);
    addRow(0, 0, 0, 1, 32'hCC, 1, 1,   1, 32'hCC, 1, 1, 3'd1);
    addRow(0, 0, 0, 0, 32'h00, 0, 1,   0, 32'hCC, 1, 1, 3'd1);
    addRow(0, 0, 0, 0, 32'h00, 0, 1,   0, 32'hCC, 1, 1, 3'd2);
    addRow(0, 0, 0, 1, 32'h11, 1, 0,   1, 32'h11, 1, 1, 3'd3);
    addRow(0, 0, 0, 1, 32'h22, 0, 0,   1, 32'h11, 1, 0, 3'd3);
    addRow(0, 1, 0, 1, 32'h33, 1, 0,   0, 32'h13, 0, 1, 3'd3);
    addRow(0, 0, 0, 0, 32'h00, 0, 0,   0, 32'h13, 0, 1, 3'd4);
    addRow(0, 0, 0, 1, 32'h44, 1, 1,   1, 32'h44, 1, 1, 3'd5);
    addRow(0, 0, 1, 1, 32'h55, 0, 1,   1, 32'h44, 1, 0, 3'd5);
    addRow(0, 0, 1, 1, 32'h55, 0, 1,   1, 32'h44, 1, 0, 3'd5);
    addRow(0, 0, 1, 1, 32'h55, 0, 1,   1, 32'h44, 1, 0, 3'd5);
    addRow(0, 0, 0, 0, 32'h00, 0, 1,   0, 32'h44, 1, 1, 3'd5);
    addRow(0, 0, 0, 0, 32'h00, 0, 1,   0, 32'h44, 1, 1, 3'd6);
    addRow(0, 0, 0, 0, 32'h00, 0, 1,   0, 32'h44, 1, 1, 3'd7);
    addRow(0, 0, 0, 0, 32'h00, 0, 1,   0, 32'h44, 1, 1, 3'd7);
    addRow(0, 1, 0, 0, 32'h00, 0, 1,   0, 32'h13, 0, 1, 3'd7);
    addRow(1, 0, 0, 0, 32'h00, 0, 1,   0, 32'h13, 0, 1, 3'd0);

    for (int n = 0; n < tbl.size(); n++) begin
      applyStimulus(tbl[n].rst, tbl[n].flush, tbl[n].stall, tbl[n].iv,
                    168'(tbl[n].idata), tbl[n].iwr, tbl[n].ordy);
      step();
      cmp($sformatf("tbl[%0d] out_valid", n), ent_t'(ov0), ent_t'(tbl[n].ev));
      cmp($sformatf("tbl[%0d] out_data", n), ent_t'(od0), ent_t'(tbl[n].ed));
      cmp($sformatf("tbl[%0d] out_wr_en", n), ent_t'(ow0), ent_t'(tbl[n].ew));
      cmp($sformatf("tbl[%0d] in_ready", n), ent_t'(ir0), ent_t'(tbl[n].eir));
      cmp($sformatf("tbl[%0d] bubble_cnt", n), ent_t'(bc0), ent_t'(tbl[n].ec));
    end

    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0, 1, 168'(k), 1, 1);
      step();
      cmp($sformatf("stream %0d dut0 out_data", k), ent_t'(od0), ent_t'(k));
      cmp($sformatf("stream %0d dut0 in_ready", k), ent_t'(ir0), ent_t'(1));
      cmp($sformatf("stream %0d dut1 out_data", k), ent_t'(od1), ent_t'(k));
      cmp($sformatf("stream %0d dut1 in_ready", k), ent_t'(ir1), ent_t'(1));
    end
    applyStimulus(0, 0, 0, 0, '0, 0, 1);
    step();

    for (int c = 0; c < 3000; c++) begin
      logic [167:0] d;
      for (int j = 0; j < 6; j++) d[j*28 +: 28] = 28'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                    d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
